hilo_md_unit: RTL and testbench
===============================

# hilo_md_unit

Multiply/divide responder for the EX stage: consumes the 4-bit `HILO_type` command the decoder issues per instruction, runs multi-cycle signed/unsigned multiply and divide into private HI/LO registers, services mthi/mtlo writes and drives mfhi/mflo read data. It exposes `start`/`busy` so the hazard unit can stall any HILO-class instruction in D while an operation is in flight, and a `flush` input so an excepting or interrupted instruction never commits to HI/LO.

## Interface
- `MULT_CYCLES`, 5, busy cycles for mult/multu (and madd/maddu when built); legal 1..31.
- `DIV_CYCLES`, 10, busy cycles for div/divu; legal 1..31.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-high; one clock domain.
- `HILO_type`  in  4  command of the E-stage instruction: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mflo, 6 mfhi, 7 mtlo, 8 mthi, 9 madd, 10 maddu; 11–15 treated as none.
- `A`  in  32  forwarded rs value.
- `B`  in  32  forwarded rt value.
- `flush`  in  1  E-stage instruction is cancelled (exception/eret/interrupt); suppresses new commits this cycle.
- `start`  out  1  combinational: accepted md command this cycle.
- `busy`  out  1  registered: operation in flight.
- `HILO_out`  out  32  combinational: HI for mfhi, LO for mflo, else 0.

## Operation
- States: IDLE, RUN. Registers: HI, LO, shadow result HI_n/LO_n, down-counter `cnt` (5 bits).
- Accept: `start = md_cmd & ~busy & ~flush`, md_cmd = types 1–4 (and 9–10 when built). On accept: latch results into HI_n/LO_n, load `cnt` with MULT_CYCLES or DIV_CYCLES, go RUN.
- RUN: `cnt` decrements each cycle; on the cycle `cnt`==1, HI<=HI_n, LO<=LO_n, busy falls next edge, state IDLE.
- mult: {HI,LO} = signed(A)×signed(B), 64-bit. multu: unsigned 64-bit.
- div: LO = signed quotient truncated toward zero, HI = remainder with sign of dividend. 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0. divu: unsigned.
- Divide by zero (B==0): command accepted, busy runs full DIV_CYCLES, HI/LO left unchanged.
- mthi/mtlo: when `~busy & ~flush`, HI (resp. LO) <= A at the edge. Issued while busy: ignored (hazard unit guarantees this does not occur; bench checks ignore).
- mfhi/mflo: HILO_out reflects current HI/LO regardless of busy; the hazard unit stalls reads while busy.
- `flush` never aborts an operation already in RUN; it only blocks that cycle's accept or mt write.
- md command while busy: not accepted, no state change.

## Timing
- Reset (async, immediate): HI=0, LO=0, HI_n=LO_n=0, cnt=0, state IDLE, busy=0; start/HILO_out follow inputs combinationally (HILO_out=0 for mf commands since HI=LO=0).
- Accept at edge T0 → busy=1 in cycles T0+1 … T0+N (N = configured cycles) → HI/LO visible and busy=0 from T0+N+1.
- Hazard unit stalls D on `(start | busy) & HILO-class in D`; the md instruction itself proceeds down the pipeline.
- mt write visible on HILO_out the cycle after its edge.
- Reset asserted mid-RUN: operation discarded, HI/LO=0.

## Configuration
- `MD_MADD_EN` defined: types 9/10 accepted; {HI,LO} <= {HI,LO} + signed/unsigned(A×B) mod 2^64, computed from HI/LO at accept, MULT_CYCLES latency.
- Undefined: types 9/10 behave as none (start=0, no state change), no accumulator adder synthesized.

## Test plan
- mult A=0xFFFFFFFE, B=3 → start=1, busy high 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA; multu same operands → HI=0x2, LO=0xFFFFFFFA.
- div A=0xFFFFFFF9(−7), B=2 → after 10 busy cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF; div 0x80000000/0xFFFFFFFF → LO=0x80000000, HI=0.
- HI=0x11, LO=0x22 preloaded via mthi/mtlo; divu A=5, B=0 → busy 10 cycles, HI=0x11, LO=0x22 unchanged.
- mult with flush=1 → start=0, busy stays 0, HI/LO unchanged; mtlo A=0x1234 with flush=1 → LO unchanged.
- mult accepted, second mult issued at T0+2 → not accepted; reset pulsed at T0+3 → busy=0, HI=LO=0 immediately.
- With `MD_MADD_EN`: HI=0, LO=0xFFFFFFFF, maddu A=1, B=1 → HI=1, LO=0 after 5 cycles; without macro same stimulus → start=0, HI/LO unchanged.

Source files
------------

// File: rtl/hilo_md_unit.sv
// hilo_md_unit: multi-cycle mult/div responder owning HI/LO, with mthi/mtlo writes and mfhi/mflo reads.
// Define MD_MADD_EN to accept madd/maddu (types 9/10) into the 64-bit HI/LO accumulator.
module hilo_md_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  HILO_type,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        flush,
  output logic        start,
  output logic        busy,
  output logic [31:0] HILO_out
);
  typedef enum logic {IDLE, RUN} state_t;
  state_t state, state_nx;
  logic [31:0] hi, lo, hi_n, lo_n;
  logic [4:0] cnt;
  logic is_mul, is_div, md_cmd, signed_op;
  logic [63:0] prod_s, prod_u, prod, mul_res, div_res, res;
  logic [31:0] mag_a, mag_b, den, quo_u, rem_u, quo, rem;
`ifdef MD_MADD_EN
  logic is_mac;
`endif
  always_comb begin
    is_mul = HILO_type == 4'd1 || HILO_type == 4'd2;
    is_div = HILO_type == 4'd3 || HILO_type == 4'd4;
    signed_op = HILO_type == 4'd1 || HILO_type == 4'd3 || HILO_type == 4'd9;
    prod_s = {{32{A[31]}}, A} * {{32{B[31]}}, B};
    prod_u = {32'd0, A} * {32'd0, B};
    prod = signed_op ? prod_s : prod_u;
`ifdef MD_MADD_EN
    is_mac = HILO_type == 4'd9 || HILO_type == 4'd10;
    md_cmd = is_mul | is_div | is_mac;
    mul_res = is_mac ? {hi, lo} + prod : prod;
`else
    md_cmd = is_mul | is_div;
    mul_res = prod;
`endif
    // signed divide on magnitudes, so 0x80000000 / -1 wraps to 0x80000000 with zero remainder
    mag_a = (signed_op & A[31]) ? -A : A;
    mag_b = (signed_op & B[31]) ? -B : B;
    den = (B == 32'd0) ? 32'd1 : mag_b;
    quo_u = mag_a / den;
    rem_u = mag_a % den;
    quo = (signed_op & (A[31] ^ B[31])) ? -quo_u : quo_u;
    rem = (signed_op & A[31]) ? -rem_u : rem_u;
    div_res = (B == 32'd0) ? {hi, lo} : {rem, quo};
    res = is_div ? div_res : mul_res;
    busy = state == RUN;
    start = md_cmd & ~busy & ~flush;
    state_nx = (state == IDLE) ? (start ? RUN : IDLE) : (cnt == 5'd1 ? IDLE : RUN);
    HILO_out = (HILO_type == 4'd6) ? hi : (HILO_type == 4'd5) ? lo : 32'd0;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      hi <= '0;
      lo <= '0;
      hi_n <= '0;
      lo_n <= '0;
      cnt <= '0;
    end else begin
      state <= state_nx;
      if (start) begin
        {hi_n, lo_n} <= res;
        cnt <= is_div ? 5'(DIV_CYCLES) : 5'(MULT_CYCLES);
      end else if (state == RUN) begin
        cnt <= cnt - 5'd1;
        if (cnt == 5'd1) begin
          hi <= hi_n;
          lo <= lo_n;
        end
      end
      if (~busy & ~flush & HILO_type == 4'd8) hi <= A;
      if (~busy & ~flush & HILO_type == 4'd7) lo <= A;
    end
  end
endmodule

// File: tb/tb_hilo_md_unit.sv
// tb_hilo_md_unit: scoreboard bench; an arithmetic HI/LO model predicts start/busy/HILO_out per cycle.
module tb_hilo_md_unit;
  localparam int MC = 5;
  localparam int DC = 10;
  logic clk = 0, reset = 1, flush = 0;
  logic [3:0] HILO_type = 0;
  logic [31:0] A = 0, B = 0;
  logic start, busy;
  logic [31:0] HILO_out;
  typedef struct {logic s; logic b; logic [31:0] h;} exp_t;
  exp_t q[$];
  int checks = 0, passed = 0;
  logic [31:0] m_hi = 0, m_lo = 0;
  logic [63:0] m_pend = 0;
  bit m_valid = 0, m_start = 0;
  int m_left = 0;

  hilo_md_unit dut (.clk(clk), .reset(reset), .HILO_type(HILO_type), .A(A), .B(B),
                    .flush(flush), .start(start), .busy(busy), .HILO_out(HILO_out));

  always #5 clk = ~clk;

  function automatic bit is_md(logic [3:0] t);
`ifdef MD_MADD_EN
    return (t >= 1 && t <= 4) || t == 9 || t == 10;
`else
    return t >= 1 && t <= 4;
`endif
  endfunction

  function automatic void model_edge();
    longint x, y;
    x = $signed(A);
    y = $signed(B);
    if (m_left > 0) begin
      m_left--;
      if (m_left == 0 && m_valid) {m_hi, m_lo} = m_pend;
    end else if (m_start) begin
      m_valid = 1;
      m_left = (HILO_type == 3 || HILO_type == 4) ? DC : MC;
      case (HILO_type)
        1: m_pend = 64'(x * y);
        2: m_pend = 64'(A) * 64'(B);
        3: if (B == 0) m_valid = 0; else m_pend = {32'(x % y), 32'(x / y)};
        4: if (B == 0) m_valid = 0; else m_pend = {A % B, A / B};
        9: m_pend = {m_hi, m_lo} + 64'(x * y);
        10: m_pend = {m_hi, m_lo} + 64'(A) * 64'(B);
        default: m_valid = 0;
      endcase
    end else if (!flush) begin
      if (HILO_type == 8) m_hi = A;
      if (HILO_type == 7) m_lo = A;
    end
  endfunction

  task automatic step(input logic [3:0] t, input logic [31:0] a, input logic [31:0] b,
                      input bit fl, input bit rs);
    exp_t e;
    @(posedge clk);
    model_edge();
    #1;
    HILO_type = t; A = a; B = b; flush = fl;
    if (rs) begin
      reset = 1;
      m_hi = 0; m_lo = 0; m_left = 0; m_valid = 0;
    end
    m_start = is_md(t) && m_left == 0 && !fl;
    e.s = m_start;
    e.b = m_left > 0;
    e.h = (t == 6) ? m_hi : (t == 5) ? m_lo : 32'd0;
    q.push_back(e);
    if (rs) begin
      @(negedge clk);
      #1 reset = 0;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
  endtask

  task automatic rd();
    step(6, 0, 0, 0, 0);
    step(5, 0, 0, 0, 0);
  endtask

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
  endtask

  initial forever begin
    @(negedge clk);
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("start", 32'(start), 32'(e.s));
      chk("busy", 32'(busy), 32'(e.b));
      chk("HILO_out", HILO_out, e.h);
    end
  end

  initial begin
    logic [31:0] a, b;
    step(6, 0, 0, 0, 1);
    step(1, 32'hFFFFFFFE, 3, 0, 0); idle(MC); rd();
    step(2, 32'hFFFFFFFE, 3, 0, 0); idle(MC); rd();
    step(3, 32'hFFFFFFF9, 2, 0, 0); idle(DC); rd();
    step(3, 32'h80000000, 32'hFFFFFFFF, 0, 0); idle(DC); rd();
    step(8, 32'h11, 0, 0, 0); step(7, 32'h22, 0, 0, 0);
    step(4, 5, 0, 0, 0); idle(DC); rd();
    step(1, 7, 9, 1, 0); rd();
    step(7, 32'h1234, 0, 1, 0); rd();
    step(1, 7, 9, 0, 0); step(0, 0, 0, 0, 0); step(1, 3, 3, 0, 0);
    step(6, 0, 0, 0, 1); step(5, 0, 0, 0, 0); idle(MC); rd();
    step(8, 0, 0, 0, 0); step(7, 32'hFFFFFFFF, 0, 0, 0);
    step(10, 1, 1, 0, 0); idle(MC); rd();
    step(9, 32'hFFFFFFFF, 32'h3, 0, 0); idle(MC); rd();
    for (int i = 0; i < 1500; i++) begin
      a = ($urandom_range(0, 3) == 0) ? 32'h80000000 : $urandom;
      case ($urandom_range(0, 4))
        0: b = 0;
        1: b = 32'hFFFFFFFF;
        2: b = $urandom_range(1, 20);
        default: b = $urandom;
      endcase
      step(4'($urandom_range(0, 15)), a, b, $urandom_range(0, 7) == 0, 0);
      if (i % 16 == 15) rd();
    end
    idle(DC + 2); rd();
    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
